// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring divider, one bit per cycle.
// Normal ops take XLEN+2 edges to done; divide-by-zero and signed overflow finish in a single edge.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN + 1);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   opa_q, opa_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   result_q, result_d;

    // Operand decode on the incoming request
    logic            rs1_sgn, rs2_sgn, s1, s2;
    logic            is_div, is_rem, div_zero, div_ovf;
    logic [XLEN-1:0] abs1, abs2, special_val;

    assign rs1_sgn = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    assign rs2_sgn = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    assign s1      = rs1_sgn & rs1[XLEN-1];
    assign s2      = rs2_sgn & rs2[XLEN-1];
    assign abs1    = s1 ? -rs1 : rs1;
    assign abs2    = s2 ? -rs2 : rs2;
    assign is_div  = op[2];
    assign is_rem  = op[2] & op[1];

    assign div_zero = is_div && (rs2 == '0);
    assign div_ovf  = is_div && !op[0] && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);

    always_comb begin
        special_val = rs1;
        if (div_zero) begin
            special_val = is_rem ? rs1 : '1;
        end else if (is_rem) begin
            special_val = '0;
        end
    end

    // acc holds {product_hi, multiplier} for multiply and {remainder, dividend/quotient} for divide
    logic [XLEN:0]     mul_sum, rem_sh, rem_diff;
    logic [2*XLEN-1:0] acc_mul, acc_div;

    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, {XLEN{acc_q[0]}} & opa_q};
    assign acc_mul  = {mul_sum, acc_q[XLEN-1:1]};
    assign rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    assign rem_diff = rem_sh - {1'b0, opa_q};
    assign acc_div  = rem_diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                     : {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_val;

    assign prod_fix = neg_q ? -acc_q : acc_q;
    assign quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem_fix  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    always_comb begin
        fix_val = rem_fix;
        case (op_q)
            OP_MUL:                        fix_val = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fix_val = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               fix_val = quo_fix;
            default:                       fix_val = rem_fix;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        opa_d    = opa_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        result_d = result_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    state_d = S_IDLE;
                    if (start) begin
                        op_d  = op;
                        opa_d = is_div ? abs2 : abs1;
                        acc_d = {{XLEN{1'b0}}, is_div ? abs1 : abs2};
                        neg_d = is_rem ? s1 : (s1 ^ s2);
                        cnt_d = '0;
                        if (div_zero || div_ovf) begin
                            result_d = special_val;
                            state_d  = S_DONE;
                        end else begin
                            state_d = S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc_d = op_q[2] ? acc_div : acc_mul;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(XLEN - 1)) begin
                        state_d = S_FIX;
                    end
                end
                S_FIX: begin
                    result_d = fix_val;
                    state_d  = S_DONE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            opa_q    <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            opa_q    <= opa_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == S_CALC) || (state_q == S_FIX);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed vectors feed a scoreboard queue, a negedge monitor checks every done pulse.
module tb_muldiv_seq;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset, start, flush;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1, rs2;
    logic            busy, done;
    logic [XLEN-1:0] result;

    always #5 clk = ~clk;

    muldiv_seq #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rs1    (rs1),
        .rs2    (rs2),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [XLEN-1:0] exp_q[$];
    int              expc_q[$];
    string           tag_q[$];
    int              n_cmp = 0;
    int              n_err = 0;
    logic [XLEN-1:0] last_exp = '0;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation, in value and in cycle
    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: result %h with nothing pending", result);
            end else begin
                logic [XLEN-1:0] e;
                int              c;
                string           t;
                e = exp_q.pop_front();
                c = expc_q.pop_front();
                t = tag_q.pop_front();
                check({t, "_result"}, result, e);
                check({t, "_cycle"}, 32'(cyc), 32'(c));
            end
        end
    end

    // Called on a negedge; start is sampled on the following posedge
    task automatic issue(input logic [2:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] e, input bit special, input string tag);
        op    = o;
        rs1   = a;
        rs2   = b;
        start = 1'b1;
        exp_q.push_back(e);
        expc_q.push_back(cyc + 1 + (special ? 0 : XLEN + 1));
        tag_q.push_back(tag);
        last_exp = e;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout: %0d results still pending after %0d cycles", exp_q.size(), bound);
            exp_q.delete();
            expc_q.delete();
            tag_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic run(input logic [2:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] e, input bit special, input string tag);
        issue(o, a, b, e, special, tag);
        wait_idle(100);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  busy_cnt;
        int  c0;
        bit  done_seen;

        reset = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = '0;
        rs1   = '0;
        rs2   = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // MUL 7*6 with busy-length measurement
        issue(3'd0, 32'd7, 32'd6, 32'd42, 1'b0, "mul_7x6");
        busy_cnt = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        check("mul_busy_cycles", 32'(busy_cnt), 32'd33);
        wait_idle(100);

        run(3'd0, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFF1, 1'b0, "mul_neg3x5");
        run(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, "mulh_m1xm1");
        run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, "mulhu_max");
        run(3'd2, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 1'b0, "mulhsu_m1x2");
        run(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, "mulh_min2");
        run(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, "mulhsu_min");
        run(3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 1'b0, "div_m7d2");
        run(3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 1'b0, "rem_m7d2");
        run(3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, "div_7dm2");
        run(3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1,        1'b0, "rem_7dm2");
        run(3'd5, 32'd100,       32'd7,        32'd14,       1'b0, "divu_100d7");
        run(3'd7, 32'd100,       32'd7,        32'd2,        1'b0, "remu_100d7");
        run(3'd5, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 1'b0, "divu_maxd1");
        run(3'd7, 32'h8000_0000, 32'd7,        32'd2,        1'b0, "remu_2p31d7");
        run(3'd4, 32'd123,       32'd0,        32'hFFFF_FFFF, 1'b1, "div_by0");
        run(3'd6, 32'd5,         32'd0,        32'd5,        1'b1, "rem_by0");
        run(3'd5, 32'd9,         32'd0,        32'hFFFF_FFFF, 1'b1, "divu_by0");
        run(3'd7, 32'd9,         32'd0,        32'd9,        1'b1, "remu_by0");
        run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "div_ovf");
        run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        1'b1, "rem_ovf");
        run(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        1'b0, "divu_big");
        run(3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, "remu_big");

        // Flush when the counter reaches 10, then flush colliding with start
        op    = 3'd5;
        rs1   = 32'd1000;
        rs2   = 32'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {31'b0, busy}, 32'd0);
        op    = 3'd0;
        rs1   = 32'd3;
        rs2   = 32'd3;
        start = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check("flush_start_busy", {31'b0, busy}, 32'd0);
        done_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) done_seen = 1'b1;
            @(negedge clk);
        end
        check("flush_no_done", {31'b0, done_seen}, 32'd0);
        check("flush_result_kept", result, last_exp);

        // Start held through busy, operands changed mid-op; the DONE-cycle start launches the second op
        c0    = cyc;
        op    = 3'd3;
        rs1   = 32'hFFFF_FFFF;
        rs2   = 32'hFFFF_FFFF;
        start = 1'b1;
        exp_q.push_back(32'hFFFF_FFFE);
        expc_q.push_back(c0 + 34);
        tag_q.push_back("held_first");
        exp_q.push_back(32'd14);
        expc_q.push_back(c0 + 68);
        tag_q.push_back("b2b_second");
        @(negedge clk);
        op  = 3'd5;
        rs1 = 32'd100;
        rs2 = 32'd7;
        repeat (33) @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_idle(100);

        // Reset in the middle of CALC
        op    = 3'd0;
        rs1   = 32'd3;
        rs2   = 32'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_busy", {31'b0, busy}, 32'd0);
        check("midreset_done", {31'b0, done}, 32'd0);
        check("midreset_result", result, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        run(3'd4, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0, "post_reset_div");
        run(3'd6, 32'd100, 32'hFFFF_FFF9, 32'd2,        1'b0, "post_reset_rem");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
